// File: rtl/align_monitor_fco_mc_pkg.sv
// Shared types and helpers for the multi-lane FCO alignment monitor.
`timescale 1ns/1ps
package align_mon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2,
        HOLD   = 2'd3
    } lane_state_t;

    // Increment v, holding at the all-ones value of a w-bit field.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? max_v : (v + 32'd1);
    endfunction

    // Zero selects the default; the result never drops below min_v.
    function automatic logic [31:0] cfg_eff(input logic [31:0] cfg, input logic [31:0] dflt,
                                            input logic [31:0] min_v);
        logic [31:0] sel;
        sel = (cfg == 32'd0) ? dflt : cfg;
        return (sel < min_v) ? min_v : sel;
    endfunction

endpackage

// File: rtl/align_monitor_fco_mc_if.sv
// Frontend stream in, per-lane alignment status out.
`timescale 1ns/1ps
interface align_monitor_fco_mc_if #(
    parameter int NUM_CH = 4,
    parameter int ERR_W  = 16
) ();
    logic [NUM_CH-1:0]       fco_in;
    logic                    word_valid;
    logic [NUM_CH-1:0]       aligned;
    logic [NUM_CH-1:0]       align_pulse;
    logic [NUM_CH-1:0]       align_err_pulse;
    logic [2*NUM_CH-1:0]     lane_state;
    logic [ERR_W*NUM_CH-1:0] err_count;
    logic                    all_aligned;

    modport master (
        output fco_in, word_valid,
        input  aligned, align_pulse, align_err_pulse, lane_state, err_count, all_aligned
    );

    modport slave (
        input  fco_in, word_valid,
        output aligned, align_pulse, align_err_pulse, lane_state, err_count, all_aligned
    );
endinterface

// File: rtl/align_monitor_fco_mc_lane.sv
// One FCO lane: edge detect, valid-word counter, lock FSM, error counter.
//   state  | meaning
//   IDLE   | waiting for the first FCO rising edge
//   ACQ    | counting consecutive good frames toward lock
//   LOCKED | aligned, last frame good
//   HOLD   | aligned, absorbing consecutive bad frames before unlock
`timescale 1ns/1ps
module align_monitor_fco_lane
    import align_mon_pkg::*;
#(
    parameter int PERIOD_W = 8,
    parameter int ERR_W    = 16
) (
    input  logic                dco_clk,
    input  logic                rst_n,
    input  logic                fco,
    input  logic                word_valid,
    input  logic [PERIOD_W-1:0] period_eff,
    input  logic [7:0]          lock_n_eff,
    input  logic [7:0]          unlock_m_eff,
    input  logic                clr_err,
    output logic                aligned,
    output logic                aligned_nxt,
    output logic                align_pulse,
    output logic                align_err_pulse,
    output logic [1:0]          state,
    output logic [ERR_W-1:0]    err_count
);
    localparam int CNT_W = PERIOD_W + 1;

    lane_state_t      state_q, state_d;
    logic [CNT_W-1:0] words_q, words_d, nw;
    logic [7:0]       good_q, good_d, bad_q, bad_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             fco_d_q;
    logic             aligned_q, aligned_d;
    logic             align_pulse_q, align_pulse_d;
    logic             align_err_pulse_q, align_err_pulse_d;
    logic             rise, hit, good_frm, bad_frm, timeout, err_evt;

    // Classify the current valid word: good frame, bad frame or missing-edge timeout.
    always_comb begin
        rise     = fco & ~fco_d_q;
        nw       = (&words_q) ? words_q : (words_q + CNT_W'(1));
        hit      = (nw == {1'b0, period_eff});
        good_frm = word_valid & rise & hit & (state_q != IDLE);
        bad_frm  = word_valid & rise & ~hit & (state_q != IDLE);
        timeout  = word_valid & ~rise & (nw == {period_eff, 1'b0}) &
                   ((state_q == LOCKED) || (state_q == HOLD));
        err_evt  = bad_frm | timeout;
    end

    // Next-state, streak counters, pulses and error counter.
    always_comb begin
        state_d           = state_q;
        words_d           = words_q;
        good_d            = good_q;
        bad_d             = bad_q;
        aligned_d         = aligned_q;
        align_pulse_d     = good_frm;
        align_err_pulse_d = err_evt;

        if (word_valid) begin
            if (state_q == IDLE) begin
                words_d = '0;
                if (rise) begin
                    state_d = ACQ;
                    good_d  = '0;
                end
            end else if (rise || timeout) begin
                words_d = '0;
            end else begin
                words_d = nw;
            end
        end

        case (state_q)
            ACQ: begin
                if (good_frm) begin
                    good_d = 8'(sat_inc(32'(good_q), 8));
                    if (({1'b0, good_q} + 9'd1) >= {1'b0, lock_n_eff}) begin
                        state_d   = LOCKED;
                        aligned_d = 1'b1;
                    end
                end else if (bad_frm) begin
                    good_d = '0;
                end
            end
            LOCKED: begin
                if (good_frm) begin
                    bad_d = '0;
                end else if (err_evt) begin
                    bad_d = 8'd1;
                    if (unlock_m_eff == 8'd1) begin
                        state_d   = ACQ;
                        aligned_d = 1'b0;
                        good_d    = '0;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (good_frm) begin
                    state_d = LOCKED;
                    bad_d   = '0;
                end else if (err_evt) begin
                    bad_d = 8'(sat_inc(32'(bad_q), 8));
                    if (({1'b0, bad_q} + 9'd1) >= {1'b0, unlock_m_eff}) begin
                        state_d   = ACQ;
                        aligned_d = 1'b0;
                        good_d    = '0;
                    end
                end
            end
            default: ;
        endcase

        // A clear in the same cycle as an error wins; the pulse above still fires.
        if (clr_err) begin
            err_d = '0;
        end else if (err_evt) begin
            err_d = ERR_W'(sat_inc(32'(err_q), ERR_W));
        end else begin
            err_d = err_q;
        end
    end

    // Lane state registers.
    always_ff @(posedge dco_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            words_q           <= '0;
            good_q            <= '0;
            bad_q             <= '0;
            err_q             <= '0;
            fco_d_q           <= 1'b0;
            aligned_q         <= 1'b0;
            align_pulse_q     <= 1'b0;
            align_err_pulse_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            words_q           <= words_d;
            good_q            <= good_d;
            bad_q             <= bad_d;
            err_q             <= err_d;
            fco_d_q           <= fco;
            aligned_q         <= aligned_d;
            align_pulse_q     <= align_pulse_d;
            align_err_pulse_q <= align_err_pulse_d;
        end
    end

    assign aligned         = aligned_q;
    assign aligned_nxt     = aligned_d;
    assign align_pulse     = align_pulse_q;
    assign align_err_pulse = align_err_pulse_q;
    assign state           = state_q;
    assign err_count       = err_q;
endmodule

// File: rtl/align_monitor_fco_mc.sv
// Multi-lane FCO alignment monitor: effective config, lane array, all_aligned.
`timescale 1ns/1ps
module align_monitor_fco_mc
    import align_mon_pkg::*;
#(
    parameter int NUM_CH             = 4,
    parameter int PERIOD_W           = 8,
    parameter int EXPECT_PERIOD_DFLT = 16,
    parameter int LOCK_N_DFLT        = 16,
    parameter int UNLOCK_M_DFLT      = 4,
    parameter int ERR_W              = 16
) (
    input  logic                  dco_clk,
    input  logic                  rst_n,
    align_monitor_fco_mc_if.slave bus,
    input  logic [PERIOD_W-1:0]   period_cfg,
    input  logic [7:0]            lock_n_cfg,
    input  logic [7:0]            unlock_m_cfg,
    input  logic                  clr_err
);
    logic [PERIOD_W-1:0]     period_eff;
    logic [7:0]              lock_n_eff, unlock_m_eff;
    logic [NUM_CH-1:0]       aligned_w, aligned_nxt, pulse_w, err_pulse_w;
    logic [2*NUM_CH-1:0]     state_w;
    logic [ERR_W*NUM_CH-1:0] err_w;
    logic                    all_aligned_q, all_aligned_d;

    // Live effective configuration; lanes pick it up at their next frame evaluation.
    always_comb begin
        period_eff   = PERIOD_W'(cfg_eff(32'(period_cfg), 32'(EXPECT_PERIOD_DFLT), 32'd2));
        lock_n_eff   = 8'(cfg_eff(32'(lock_n_cfg), 32'(LOCK_N_DFLT), 32'd1));
        unlock_m_eff = 8'(cfg_eff(32'(unlock_m_cfg), 32'(UNLOCK_M_DFLT), 32'd1));
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        align_monitor_fco_lane #(
            .PERIOD_W (PERIOD_W),
            .ERR_W    (ERR_W)
        ) u_lane (
            .dco_clk         (dco_clk),
            .rst_n           (rst_n),
            .fco             (bus.fco_in[i]),
            .word_valid      (bus.word_valid),
            .period_eff      (period_eff),
            .lock_n_eff      (lock_n_eff),
            .unlock_m_eff    (unlock_m_eff),
            .clr_err         (clr_err),
            .aligned         (aligned_w[i]),
            .aligned_nxt     (aligned_nxt[i]),
            .align_pulse     (pulse_w[i]),
            .align_err_pulse (err_pulse_w[i]),
            .state           (state_w[2*i +: 2]),
            .err_count       (err_w[i*ERR_W +: ERR_W])
        );
    end

    // all_aligned follows the lanes' next aligned value so it moves on the same edge.
    always_comb begin
        all_aligned_d = &aligned_nxt;
    end

    // all_aligned register.
    always_ff @(posedge dco_clk or negedge rst_n) begin
        if (!rst_n) begin
            all_aligned_q <= 1'b0;
        end else begin
            all_aligned_q <= all_aligned_d;
        end
    end

    assign bus.aligned         = aligned_w;
    assign bus.align_pulse     = pulse_w;
    assign bus.align_err_pulse = err_pulse_w;
    assign bus.lane_state      = state_w;
    assign bus.err_count       = err_w;
    assign bus.all_aligned     = all_aligned_q;
endmodule

// File: tb/tb_align_monitor_fco_mc.sv
// Directed bench for align_monitor_fco_mc (4 lanes, 4-bit error counters).
`timescale 1ns/1ps
module tb_align_monitor_fco_mc;
    localparam int NUM_CH = 4;
    localparam int ERR_W  = 4;

    logic       dco_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic [7:0] period_cfg   = 8'd0;
    logic [7:0] lock_n_cfg   = 8'd0;
    logic [7:0] unlock_m_cfg = 8'd0;
    logic       clr_err      = 1'b0;
    logic [3:0] last_fco     = 4'h0;
    int         n_tests = 0;
    int         n_fail  = 0;

    align_monitor_fco_mc_if #(.NUM_CH(NUM_CH), .ERR_W(ERR_W)) bus ();

    align_monitor_fco_mc #(
        .NUM_CH             (NUM_CH),
        .PERIOD_W           (8),
        .EXPECT_PERIOD_DFLT (16),
        .LOCK_N_DFLT        (16),
        .UNLOCK_M_DFLT      (4),
        .ERR_W              (ERR_W)
    ) dut (
        .dco_clk      (dco_clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .period_cfg   (period_cfg),
        .lock_n_cfg   (lock_n_cfg),
        .unlock_m_cfg (unlock_m_cfg),
        .clr_err      (clr_err)
    );

    always #5 dco_clk = ~dco_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle with the given FCO pattern and valid flag; returns 1 ns after the edge.
    task automatic word(input logic [3:0] f, input logic v);
        bus.fco_in     = f;
        bus.word_valid = v;
        last_fco       = f;
        @(posedge dco_clk);
        #1;
    endtask

    // period valid words, FCO rising on the last one for lanes in mask.
    task automatic frame(input logic [3:0] mask, input int period, input bit gap);
        for (int k = 1; k <= period; k++) begin
            if (gap) word(last_fco, 1'b0);
            word((k == period) ? mask : 4'h0, 1'b1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_aligned"}, 32'(bus.aligned), 32'h0);
        check({tag, "_all"}, 32'(bus.all_aligned), 32'h0);
        check({tag, "_state"}, 32'(bus.lane_state), 32'h0);
        check({tag, "_err"}, 32'(bus.err_count), 32'h0);
        check({tag, "_pulse"}, 32'(bus.align_pulse), 32'h0);
        check({tag, "_epulse"}, 32'(bus.align_err_pulse), 32'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.fco_in     = 4'h0;
        bus.word_valid = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge dco_clk);
        rst_n = 1'b1;

        // Lock with default config on all lanes.
        repeat (3) word(4'h0, 1'b1);
        check("idle_no_edge", 32'(bus.lane_state), 32'h00);
        word(4'hF, 1'b1);
        check("first_edge_state", 32'(bus.lane_state), 32'h55);
        check("first_edge_nopulse", 32'(bus.align_pulse | bus.align_err_pulse), 32'h0);
        repeat (15) frame(4'hF, 16, 1'b0);
        check("lock15_aligned", 32'(bus.aligned), 32'h0);
        check("lock15_pulse", 32'(bus.align_pulse), 32'hF);
        check("lock15_all", 32'(bus.all_aligned), 32'h0);
        frame(4'hF, 16, 1'b0);
        check("lock16_aligned", 32'(bus.aligned), 32'hF);
        check("lock16_all", 32'(bus.all_aligned), 32'h1);
        check("lock16_state", 32'(bus.lane_state), 32'hAA);
        check("lock16_err", 32'(bus.err_count), 32'h0);
        word(4'h0, 1'b0);
        check("pulse_one_cycle", 32'(bus.align_pulse), 32'h0);

        // Hysteresis: three bad frames hold, a good frame relocks, four bad frames unlock.
        unlock_m_cfg = 8'd4;
        frame(4'hF, 15, 1'b0);
        check("bad1_epulse", 32'(bus.align_err_pulse), 32'hF);
        check("bad1_pulse", 32'(bus.align_pulse), 32'h0);
        check("bad1_state", 32'(bus.lane_state), 32'hFF);
        repeat (2) frame(4'hF, 15, 1'b0);
        check("bad3_state_hold", 32'(bus.lane_state[3:2]), 32'h3);
        check("bad3_aligned", 32'(bus.aligned[1]), 32'h1);
        check("bad3_err", 32'(bus.err_count), 32'h3333);
        check("bad3_all", 32'(bus.all_aligned), 32'h1);
        frame(4'hF, 16, 1'b0);
        check("relock_state", 32'(bus.lane_state), 32'hAA);
        check("relock_pulse", 32'(bus.align_pulse), 32'hF);
        repeat (3) frame(4'hF, 15, 1'b0);
        check("hold3_aligned", 32'(bus.aligned), 32'hF);
        check("hold3_err", 32'(bus.err_count), 32'h6666);
        frame(4'hF, 15, 1'b0);
        check("unlock_aligned", 32'(bus.aligned), 32'h0);
        check("unlock_state", 32'(bus.lane_state), 32'h55);
        check("unlock_err1", 32'(bus.err_count[7:4]), 32'h7);
        check("unlock_all", 32'(bus.all_aligned), 32'h0);

        // Timeout: only lane 0 locked, FCO held low everywhere.
        repeat (16) frame(4'h1, 16, 1'b0);
        check("to_lock_aligned", 32'(bus.aligned), 32'h1);
        check("to_lock_state", 32'(bus.lane_state), 32'h56);
        for (int t = 1; t <= 2; t++) begin
            repeat (31) word(4'h0, 1'b1);
            check("to_early", 32'(bus.align_err_pulse), 32'h0);
            word(4'h0, 1'b1);
            check("to_epulse", 32'(bus.align_err_pulse), 32'h1);
            check("to_err", 32'(bus.err_count), 32'h7777 + 32'(t));
        end
        check("to_state", 32'(bus.lane_state), 32'h57);
        check("to_aligned", 32'(bus.aligned), 32'h1);

        // Saturation and clear.
        repeat (5) frame(4'hF, 5, 1'b0);
        check("sat5_err", 32'(bus.err_count), 32'hCCCE);
        repeat (15) frame(4'hF, 5, 1'b0);
        check("sat20_err", 32'(bus.err_count), 32'hFFFF);
        check("sat20_epulse", 32'(bus.align_err_pulse), 32'hF);
        check("sat20_state", 32'(bus.lane_state), 32'h55);
        repeat (4) word(4'h0, 1'b1);
        clr_err = 1'b1;
        word(4'hF, 1'b1);
        clr_err = 1'b0;
        check("clr_err", 32'(bus.err_count), 32'h0);
        check("clr_epulse", 32'(bus.align_err_pulse), 32'hF);
        check("clr_excl", 32'(bus.align_pulse & bus.align_err_pulse), 32'h0);
        frame(4'hF, 5, 1'b0);
        check("after_clr_err", 32'(bus.err_count), 32'h1111);

        // Fresh start, then period 10 with word_valid toggling.
        #2;
        rst_n = 1'b0;
        bus.fco_in = 4'h0;
        bus.word_valid = 1'b0;
        period_cfg = 8'd10;
        #1;
        check_all_zero("rst2");
        #10;
        @(negedge dco_clk);
        rst_n = 1'b1;
        word(4'hF, 1'b1);
        check("gap_edge_state", 32'(bus.lane_state), 32'h55);
        repeat (15) frame(4'hF, 10, 1'b1);
        check("gap15_aligned", 32'(bus.aligned), 32'h0);
        check("gap15_pulse", 32'(bus.align_pulse), 32'hF);
        frame(4'hF, 10, 1'b1);
        check("gap16_aligned", 32'(bus.aligned), 32'hF);
        check("gap16_all", 32'(bus.all_aligned), 32'h1);
        check("gap16_err", 32'(bus.err_count), 32'h0);
        word(4'hF, 1'b0);
        check("gap_fill_pulse", 32'(bus.align_pulse), 32'h0);

        // Asynchronous reset while locked, then relock from IDLE.
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        bus.fco_in = 4'h0;
        bus.word_valid = 1'b0;
        #10;
        @(negedge dco_clk);
        rst_n = 1'b1;
        frame(4'hF, 10, 1'b0);
        check("relock_edge_state", 32'(bus.lane_state), 32'h55);
        check("relock_edge_nopulse", 32'(bus.align_pulse), 32'h0);
        repeat (15) frame(4'hF, 10, 1'b0);
        check("relock15_aligned", 32'(bus.aligned), 32'h0);
        frame(4'hF, 10, 1'b0);
        check("relock16_aligned", 32'(bus.aligned), 32'hF);
        check("relock16_all", 32'(bus.all_aligned), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/align_monitor_fco_mc.md
Name: align_monitor_fco_mc

Overview:
- Multi-channel frame-clock (FCO) alignment monitor for the ADC frontend. One instance covers NUM_CH LVDS lanes on one DCO clock.
- Per lane: checks that FCO rising edges arrive every period_eff valid words. Lock is declared after N consecutive good frames. Lock is dropped only after M consecutive bad frames (hysteresis).
- Adds missing-edge timeout detection and clearable saturating per-lane error counters.
- Feeds CSR status and the deserializer bit-slip controller.

Parameters:
- NUM_CH, 4: number of FCO lanes monitored.
- PERIOD_W, 8: width of period_cfg and of the per-lane word counter (counter is PERIOD_W+1 bits).
- EXPECT_PERIOD_DFLT, 16: frame period in valid words, used when period_cfg==0.
- LOCK_N_DFLT, 16: consecutive good frames needed to lock, used when lock_n_cfg==0.
- UNLOCK_M_DFLT, 4: consecutive bad frames needed to unlock, used when unlock_m_cfg==0.
- ERR_W, 16: width of each per-lane error counter.

Ports:
- dco_clk  in  1  DCO clock, the single clock of the block.
- rst_n  in  1  asynchronous active-low reset.
- fco_in  in  NUM_CH  per-lane FCO sample.
- word_valid  in  1  shared deserialized-word strobe.
- period_cfg  in  PERIOD_W  expected frame period; 0 selects the default.
- lock_n_cfg  in  8  lock threshold; 0 selects the default.
- unlock_m_cfg  in  8  unlock threshold; 0 selects the default.
- clr_err  in  1  synchronous clear of all error counters.
- aligned  out  NUM_CH  per-lane lock status.
- align_pulse  out  NUM_CH  1-cycle pulse on each good frame.
- align_err_pulse  out  NUM_CH  1-cycle pulse on each bad or missing frame.
- lane_state  out  2*NUM_CH  per-lane FSM state; lane i occupies bits [2i+1:2i].
- err_count  out  ERR_W*NUM_CH  per-lane saturating error counters, lane i at slice i.
- all_aligned  out  1  registered AND of aligned[].

Behaviour:
- Reset (async, rst_n=0):
  - aligned, align_pulse, align_err_pulse, err_count and all_aligned are all 0.
  - lane_state = IDLE. Word counters and streak counters are 0. fco_d = 0.
- Effective config, combinational, evaluated live:
  - period_eff = period_cfg, or EXPECT_PERIOD_DFLT if 0; clamped to a minimum of 2.
  - lock_n_eff and unlock_m_eff: cfg value, or the default if 0; clamped to a minimum of 1.
  - A config change takes effect at the next frame evaluation; state is not reset.
- Edge detect:
  - fco_d[i] registers every cycle, independent of word_valid.
  - rise[i] = fco_in[i] & ~fco_d[i].
- Evaluation happens only on cycles with word_valid=1. Let nw = words+1, saturating at 2^(PERIOD_W+1)-1.
  - Good frame: rise and nw==period_eff. Asserts align_pulse; words <= 0.
  - Bad frame: rise and nw!=period_eff. Asserts align_err_pulse; words <= 0.
  - Timeout: no rise and nw==2*period_eff, in state LOCKED or HOLD only. Treated as a bad frame; words <= 0.
  - Otherwise: words <= nw.
- Per-lane FSM, encoding IDLE=0, ACQ=1, LOCKED=2, HOLD=3:
  - IDLE: first rise -> ACQ with words=0, good=0. No pulses; no error counted.
  - ACQ:
    - Good frame: good++ (saturates at 255). If good+1 >= lock_n_eff -> LOCKED and aligned<=1.
    - Bad frame: good<=0 and count the error. Stay in ACQ.
  - LOCKED:
    - Good frame: stay; bad<=0.
    - Bad frame or timeout: count the error and set bad<=1. If unlock_m_eff==1 -> ACQ with aligned<=0 and good<=0; else -> HOLD.
  - HOLD (aligned stays 1):
    - Good frame: -> LOCKED, bad<=0.
    - Bad frame or timeout: bad++ and count the error. If bad+1 >= unlock_m_eff -> ACQ with aligned<=0 and good<=0.
- Pulses: registered; exactly one cycle per evaluated frame; align_pulse and align_err_pulse are never both high on one lane.
- Timing: aligned and all_aligned update in the same edge as the frame pulse. all_aligned is registered from the next-state value of aligned, so it has the same latency.
- err_count[i]:
  - Increments by 1 on every bad frame or timeout; saturates at all-ones.
  - clr_err=1 forces all counters to 0. If an error occurs in the same cycle, clr_err wins and the error is not counted; the pulse still fires.
- Lanes are fully independent except for the shared word_valid, config inputs and clr_err.

Decomposition:
- Package align_mon_pkg:
  - lane_state_t enum, 2-bit: IDLE, ACQ, LOCKED, HOLD.
  - Function sat_inc, parameterised by width.
  - Function cfg_eff (zero -> default, then clamp).
- Sub-module align_monitor_fco_lane: one lane's edge detect, word counter, FSM and error counter.
- Top level: generate loop over NUM_CH lanes, effective-config logic, and the all_aligned register.

Test Plan:
- Lock: NUM_CH=4, all cfg=0, word_valid=1, FCO every 16 words on all lanes -> aligned[i] rises on the 16th good frame after the first edge; all_aligned one register stage later, same edge; err_count=0.
- Hysteresis: locked lane 1, then 3 frames of period 15 with unlock_m_cfg=4 -> lane_state[1]=HOLD, aligned[1]=1, err_count[1]=3. One good frame -> LOCKED. Then 4 bad frames -> aligned[1]=0, state ACQ, err_count[1]=7.
- Timeout: locked lane 0, FCO held low -> align_err_pulse[0] every 32 valid words, err_count[0] increments each time. Non-locked lanes raise no timeout error.
- Gaps and config: period_cfg=10, word_valid toggling 1/0, FCO every 10 valid words -> lock is reached; frame count is unaffected by the invalid cycles.
- Saturation and clear: ERR_W=4, 20 bad frames -> err_count=15. Assert clr_err in the same cycle as a bad frame -> err_count=0 and align_err_pulse=1.
- Reset mid-lock: assert rst_n=0 asynchronously while locked -> all outputs 0 immediately. After release, the lane re-enters IDLE and needs a first edge plus N good frames to lock again.
